// File: rtl/break_count_scheduler_if.sv
// Fetch-side and cluster-side signals of the break-count scheduler.
// The master modport is the scheduler; the slave side is the fetch unit plus cluster.
interface break_count_scheduler_if #(
  parameter int CLUSTER_SIZE = 20,
  parameter int NSAT         = 3,
  parameter int REDUCE       = 1,
  parameter int MAX_CLAUSES  = 1024
);
  localparam int W     = NSAT - REDUCE;
  localparam int CNT_W = $clog2(MAX_CLAUSES + 1);

  logic                      fetch_req_o;
  logic [CNT_W-1:0]          fetch_idx_o;
  logic                      fetch_valid_i;
  logic [W*CLUSTER_SIZE-1:0] fetch_val_i;
  logic [W*CLUSTER_SIZE-1:0] fetch_neg_i;
  logic [W*CLUSTER_SIZE-1:0] ce_val_o;
  logic [W*CLUSTER_SIZE-1:0] ce_neg_o;
  logic [CLUSTER_SIZE-1:0]   ce_break_i;

  modport master (
    output fetch_req_o, fetch_idx_o, ce_val_o, ce_neg_o,
    input  fetch_valid_i, fetch_val_i, fetch_neg_i, ce_break_i
  );

  modport slave (
    input  fetch_req_o, fetch_idx_o, ce_val_o, ce_neg_o,
    output fetch_valid_i, fetch_val_i, fetch_neg_i, ce_break_i
  );
endinterface

// File: rtl/break_count_scheduler.sv
// Walks one variable's occurrence list through the clause evaluator cluster in
// CLUSTER_SIZE batches and totals the lanes that report a break.
//
// state  | meaning
// IDLE   | waiting for start_i
// RUN    | requesting / accepting occurrence-list batches
// DRAIN  | all batches issued, waiting for cluster results to retire
// DONE   | one-cycle done_o pulse, break_count_o just updated
module break_count_scheduler #(
  parameter int CLUSTER_SIZE = 20,
  parameter int NSAT         = 3,
  parameter int REDUCE       = 1,
  parameter int CE_LATENCY   = 1,
  parameter int MAX_CLAUSES  = 1024,
  parameter int CNT_W        = $clog2(MAX_CLAUSES + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         num_clauses_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         break_count_o,
  break_count_scheduler_if.master  bus
);
  localparam int W = NSAT - REDUCE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CS_C  = CNT_W'(CLUSTER_SIZE);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CLAUSES);

  logic [1:0]                state;
  logic [CNT_W-1:0]          remaining;
  logic [CNT_W-1:0]          fetch_idx;
  logic [CNT_W-1:0]          acc;
  logic [CNT_W-1:0]          acc_nx;
  logic [CNT_W-1:0]          contrib;
  logic [CNT_W-1:0]          take;
  logic [CNT_W-1:0]          start_n;
  logic [CNT_W-1:0]          break_count;
  logic [CLUSTER_SIZE-1:0]   lane_mask;
  logic [W*CLUSTER_SIZE-1:0] lane_bits;
  logic [W*CLUSTER_SIZE-1:0] ce_val;
  logic [W*CLUSTER_SIZE-1:0] ce_neg;
  logic [CLUSTER_SIZE-1:0]   mask_pipe [CE_LATENCY+1];
  logic [CE_LATENCY:0]       tag_pipe;
  logic                      fetch_req;
  logic                      accept;
  logic                      last_batch;
  logic                      early_busy;

  function automatic logic [CNT_W-1:0] popcount(input logic [CLUSTER_SIZE-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CLUSTER_SIZE; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  always_comb begin
    fetch_req  = (state == S_RUN);
    // abort wins over a coincident accept so an aborted run never issues a new batch
    accept     = fetch_req & bus.fetch_valid_i & ~abort_i;
    take       = (remaining > CS_C) ? CS_C : remaining;
    last_batch = (remaining <= CS_C);
    start_n    = (num_clauses_i > MAX_C) ? MAX_C : num_clauses_i;

    lane_mask = '0;
    lane_bits = '0;
    for (int i = 0; i < CLUSTER_SIZE; i++) begin
      lane_mask[i]         = (CNT_W'(i) < take);
      lane_bits[i*W +: W]  = {W{lane_mask[i]}};
    end

    // results still in flight other than the one retiring this cycle
    early_busy = 1'b0;
    for (int j = 0; j < CE_LATENCY; j++) early_busy = early_busy | tag_pipe[j];

    contrib = tag_pipe[CE_LATENCY] ? popcount(bus.ce_break_i & mask_pipe[CE_LATENCY]) : '0;
    acc_nx  = acc + contrib;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      remaining   <= '0;
      fetch_idx   <= '0;
      acc         <= '0;
      break_count <= '0;
      ce_val      <= '0;
      ce_neg      <= '0;
      tag_pipe    <= '0;
      for (int j = 0; j <= CE_LATENCY; j++) mask_pipe[j] <= '0;
    end else begin
      tag_pipe[0]  <= accept;
      mask_pipe[0] <= lane_mask;
      for (int j = 1; j <= CE_LATENCY; j++) begin
        tag_pipe[j]  <= tag_pipe[j-1];
        mask_pipe[j] <= mask_pipe[j-1];
      end
      acc <= acc_nx;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            remaining <= start_n;
            fetch_idx <= '0;
            acc       <= '0;
            state     <= (start_n == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state    <= S_IDLE;
            tag_pipe <= '0;
          end else if (accept) begin
            ce_val    <= bus.fetch_val_i & lane_bits;
            ce_neg    <= bus.fetch_neg_i & lane_bits;
            remaining <= remaining - take;
            fetch_idx <= fetch_idx + CS_C;
            if (last_batch) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort_i) begin
            state    <= S_IDLE;
            tag_pipe <= '0;
          end else if (!early_busy) begin
            state       <= S_DONE;
            break_count <= acc_nx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = (state != S_IDLE);
  assign done_o          = (state == S_DONE);
  assign break_count_o   = break_count;
  assign bus.fetch_req_o = fetch_req;
  assign bus.fetch_idx_o = fetch_idx;
  assign bus.ce_val_o    = ce_val;
  assign bus.ce_neg_o    = ce_neg;
endmodule

// File: tb/tb_break_count_scheduler.sv
// Directed + randomized bench for break_count_scheduler with a behavioural
// clause-evaluator cluster and a clause-level reference count.
module tb_break_count_scheduler;
  localparam int CS     = 20;
  localparam int NSAT   = 3;
  localparam int REDUCE = 1;
  localparam int W      = NSAT - REDUCE;
  localparam int CE_LAT = 1;
  localparam int MAXC   = 1024;
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam int MEMN   = 1100;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_clauses;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] break_count;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  logic [W-1:0] mem_val [MEMN];
  logic [W-1:0] mem_neg [MEMN];

  break_count_scheduler_if #(.CLUSTER_SIZE(CS), .NSAT(NSAT), .REDUCE(REDUCE),
                             .MAX_CLAUSES(MAXC)) bus ();

  break_count_scheduler #(.CLUSTER_SIZE(CS), .NSAT(NSAT), .REDUCE(REDUCE),
                          .CE_LATENCY(CE_LAT), .MAX_CLAUSES(MAXC)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .num_clauses_i (num_clauses),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .break_count_o (break_count),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  // cluster model: a clause breaks when every remaining literal is false (val == neg)
  always @(posedge clk) begin
    if (reset) bus.ce_break_i <= '0;
    else if (mode == 1) bus.ce_break_i <= '1;
    else if (mode == 2) bus.ce_break_i <= 20'h55555;
    else
      for (int i = 0; i < CS; i++)
        bus.ce_break_i[i] <= (bus.ce_val_o[i*W +: W] == bus.ce_neg_o[i*W +: W]);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input int n, input int md);
    int nn, cnt;
    nn  = (n > MAXC) ? MAXC : n;
    cnt = 0;
    for (int c = 0; c < nn; c++) begin
      if (md == 1) cnt++;
      else if (md == 2) begin if (((c % CS) % 2) == 0) cnt++; end
      else if (mem_val[c] == mem_neg[c]) cnt++;
    end
    return cnt;
  endfunction

  task automatic drive_fetch_data();
    int c;
    for (int i = 0; i < CS; i++) begin
      c = int'(bus.fetch_idx_o) + i;
      bus.fetch_val_i[i*W +: W] = (c < MEMN) ? mem_val[c] : '0;
      bus.fetch_neg_i[i*W +: W] = (c < MEMN) ? mem_neg[c] : '0;
    end
  endtask

  // called at a negedge; returns at a negedge
  task automatic run_case(input string tag, input int n, input int stall, input int md,
                          input int abort_after, input bit poke_start);
    int nn, exp_batches, exp_lat, exp_cnt, prev_count;
    int batches, dones, done_cyc, done_val, rem, take, last_idx, last_take;
    int bad_idx, bad_data, unstable, stall_cnt, cyc, prev_idx, c;
    bit prev_req, prev_acc, was_acc, req_seen, aborted;
    logic [W-1:0] ev, en;

    nn          = (n > MAXC) ? MAXC : n;
    exp_batches = (nn + CS - 1) / CS;
    exp_lat     = (nn == 0) ? 2 : 2 + exp_batches * (stall + 1) + CE_LAT;
    exp_cnt     = ref_count(n, md);
    prev_count  = int'(break_count);
    mode        = md;
    batches = 0; dones = 0; done_cyc = -1; done_val = -1; rem = nn;
    last_idx = 0; last_take = 0; bad_idx = 0; bad_data = 0; unstable = 0;
    stall_cnt = 0; prev_idx = 0; prev_req = 0; prev_acc = 0; req_seen = 0; aborted = 0;

    num_clauses = CNT_W'(n);
    start = 1'b1;
    bus.fetch_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= exp_lat + 6) begin
      if (prev_acc) begin
        for (int i = 0; i < CS; i++) begin
          c  = last_idx + i;
          ev = (i < last_take) ? mem_val[c] : '0;
          en = (i < last_take) ? mem_neg[c] : '0;
          if (bus.ce_val_o[i*W +: W] !== ev || bus.ce_neg_o[i*W +: W] !== en) bad_data++;
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) begin done_cyc = cyc; done_val = int'(break_count); end
      end
      if (bus.fetch_req_o) req_seen = 1;
      if (bus.fetch_req_o && prev_req && !prev_acc && int'(bus.fetch_idx_o) != prev_idx) unstable++;

      start = (poke_start && cyc == 2);
      if (start) num_clauses = CNT_W'(5);
      abort = 1'b0;
      if (abort_after > 0 && batches == abort_after && !aborted) begin
        abort = 1'b1; aborted = 1;
      end

      was_acc = 0;
      drive_fetch_data();
      if (bus.fetch_req_o && !abort) begin
        if (stall_cnt < stall) begin
          bus.fetch_valid_i = 1'b0;
          stall_cnt++;
        end else begin
          bus.fetch_valid_i = 1'b1;
          stall_cnt = 0;
          was_acc = 1;
          if (int'(bus.fetch_idx_o) != batches * CS) bad_idx++;
          take = (rem > CS) ? CS : rem;
          rem -= take;
          last_idx = int'(bus.fetch_idx_o);
          last_take = take;
          batches++;
        end
      end else if (abort) begin
        bus.fetch_valid_i = 1'b0;
      end else begin
        bus.fetch_valid_i = 1'($urandom_range(0, 1));
      end
      prev_req = bus.fetch_req_o;
      prev_idx = int'(bus.fetch_idx_o);
      prev_acc = was_acc;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    bus.fetch_valid_i = 1'b0;

    if (abort_after > 0) begin
      chk({tag, " batches"}, batches, abort_after);
      chk({tag, " no_done"}, dones, 0);
      chk({tag, " count_kept"}, break_count, prev_count);
    end else begin
      chk({tag, " batches"}, batches, exp_batches);
      chk({tag, " done_pulses"}, dones, 1);
      chk({tag, " done_cycle"}, done_cyc, exp_lat);
      chk({tag, " count"}, done_val, exp_cnt);
      chk({tag, " count_hold"}, break_count, exp_cnt);
      chk({tag, " batch_idx"}, bad_idx, 0);
      chk({tag, " ce_data"}, bad_data, 0);
      if (stall > 0) chk({tag, " idx_stable"}, unstable, 0);
      if (nn == 0) chk({tag, " no_req"}, req_seen, 0);
    end
    chk({tag, " idle_after"}, busy, 0);
  endtask

  initial begin
    int rn, rs;
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_clauses = '0;
    bus.fetch_valid_i = 1'b0; bus.fetch_val_i = '0; bus.fetch_neg_i = '0;
    for (int c = 0; c < MEMN; c++) begin
      mem_val[c] = W'($urandom);
      mem_neg[c] = W'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst count", break_count, 0);
    chk("rst req", bus.fetch_req_o, 0);
    chk("rst idx", bus.fetch_idx_o, 0);
    chk("rst ce_val", bus.ce_val_o, 0);
    chk("rst ce_neg", bus.ce_neg_o, 0);
    reset = 1'b0;
    @(negedge clk);

    run_case("partial", 45, 0, 1, 0, 0);
    run_case("stalled", 40, 3, 2, 0, 0);
    run_case("empty", 0, 0, 0, 0, 0);
    run_case("clamp", 2000, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      rn = int'($urandom_range(1, 300));
      rs = int'($urandom_range(0, 2));
      run_case($sformatf("rand%0d", k), rn, rs, 0, 0, 0);
    end
    run_case("abort", 100, 0, 1, 1, 0);
    run_case("restart", 20, 0, 0, 0, 0);
    run_case("busy_start", 60, 0, 1, 0, 1);

    // reset while draining: N=20 accepts at edge 1, DRAIN during cycle 2
    mode = 1;
    num_clauses = CNT_W'(20);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    drive_fetch_data();
    bus.fetch_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.fetch_valid_i = 1'b0;
    chk("drain busy", busy, 1);
    chk("drain req", bus.fetch_req_o, 0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst count", break_count, 0);
    chk("mid_rst idx", bus.fetch_idx_o, 0);
    chk("mid_rst ce_val", bus.ce_val_o, 0);
    chk("mid_rst ce_neg", bus.ce_neg_o, 0);
    rn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) rn++;
    end
    chk("mid_rst no_done", rn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
